// File: rtl/rggen_bit_field_event_pkg.sv
// Shared enumerations for the event/status bit field family.
// Parameter types for software write/read behaviour and hardware set qualification.
package rggen_bit_field_event_pkg;

    typedef enum logic [2:0] {
        W0C   = 3'd0,
        W1C   = 3'd1,
        W0S   = 3'd2,
        W1S   = 3'd3,
        WNONE = 3'd4
    } sw_write_mode_e;

    typedef enum logic [1:0] {
        RNONE = 2'd0,
        RCLR  = 2'd1,
        RSET  = 2'd2
    } sw_read_action_e;

    typedef enum logic [1:0] {
        LEVEL = 2'd0,
        RISE  = 2'd1,
        FALL  = 2'd2
    } hw_set_mode_e;

endpackage

// File: rtl/rggen_bit_field_if.sv
// Register block to bit field connection: access qualifiers in, read data and value out.
interface rggen_bit_field_if #(
    parameter int WIDTH = 1
);
    logic             valid;
    logic [WIDTH-1:0] read_mask;
    logic [WIDTH-1:0] write_mask;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] value;

    modport master (
        output valid, read_mask, write_mask, write_data,
        input  read_data, value
    );

    modport bit_field (
        input  valid, read_mask, write_mask, write_data,
        output read_data, value
    );
endinterface

// File: rtl/rggen_bit_field_edge_detect.sv
// Qualifies a per-bit hardware event as level, rising edge or falling edge.
// set_q starts at 0 so a line already high at reset release counts as a rising edge.
module rggen_bit_field_edge_detect
    import rggen_bit_field_event_pkg::*;
#(
    parameter int           WIDTH = 1,
    parameter hw_set_mode_e MODE  = LEVEL
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_set,
    output logic [WIDTH-1:0] o_hw_set
);

    logic [WIDTH-1:0] set_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            set_q <= '0;
        end else begin
            set_q <= i_set;
        end
    end

    always_comb begin
        case (MODE)
            RISE:    o_hw_set = i_set & ~set_q;
            FALL:    o_hw_set = ~i_set & set_q;
            default: o_hw_set = i_set;
        endcase
    end

endmodule

// File: rtl/rggen_bit_field_event_status.sv
// Status field of hardware-settable event flags with software write/read side effects,
// sticky per-bit overflow and a registered interrupt request.
module rggen_bit_field_event_status
    import rggen_bit_field_event_pkg::*;
#(
    parameter int               WIDTH          = 1,
    parameter logic [WIDTH-1:0] INITIAL_VALUE  = '0,
    parameter sw_write_mode_e   SW_WRITE_MODE  = W1C,
    parameter sw_read_action_e  SW_READ_ACTION = RNONE,
    parameter hw_set_mode_e     HW_SET_MODE    = LEVEL,
    parameter bit               HW_PRIORITY    = 1'b1
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    rggen_bit_field_if.bit_field     bit_field_if,
    input  logic [WIDTH-1:0]         i_set,
    input  logic [WIDTH-1:0]         i_clear,
    input  logic [WIDTH-1:0]         i_irq_enable,
    output logic [WIDTH-1:0]         o_value,
    output logic [WIDTH-1:0]         o_overflow,
    output logic                     o_irq
);

    logic             read_access;
    logic             write_access;
    logic [WIDTH-1:0] write_hit;
    logic [WIDTH-1:0] hw_set;
    logic [WIDTH-1:0] hw_effective;
    logic [WIDTH-1:0] sw_clear;
    logic [WIDTH-1:0] sw_set;
    logic [WIDTH-1:0] overflow_set;
    logic [WIDTH-1:0] value_reg;
    logic [WIDTH-1:0] value_next;
    logic [WIDTH-1:0] overflow_reg;
    logic [WIDTH-1:0] overflow_next;
    logic             irq_reg;
    logic             irq_next;

    rggen_bit_field_edge_detect #(
        .WIDTH (WIDTH),
        .MODE  (HW_SET_MODE)
    ) u_edge_detect (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_set    (i_set),
        .o_hw_set (hw_set)
    );

    // A non-zero read mask makes the access a read even if write_mask is also set.
    assign read_access  = bit_field_if.valid && (|bit_field_if.read_mask);
    assign write_access = bit_field_if.valid && !(|bit_field_if.read_mask)
                          && (|bit_field_if.write_mask);
    assign write_hit    = {WIDTH{write_access}} & bit_field_if.write_mask;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign sw_clear[gi] =
            (write_hit[gi] && (((SW_WRITE_MODE == W0C) && !bit_field_if.write_data[gi]) ||
                               ((SW_WRITE_MODE == W1C) &&  bit_field_if.write_data[gi]))) ||
            (read_access && (SW_READ_ACTION == RCLR));

        assign sw_set[gi] =
            (write_hit[gi] && (((SW_WRITE_MODE == W0S) && !bit_field_if.write_data[gi]) ||
                               ((SW_WRITE_MODE == W1S) &&  bit_field_if.write_data[gi]))) ||
            (read_access && (SW_READ_ACTION == RSET));

        // With software priority a same-cycle software clear swallows the event.
        assign hw_effective[gi] = hw_set[gi] && (HW_PRIORITY || !sw_clear[gi]);

        assign value_next[gi] = (value_reg[gi] && !i_clear[gi] && !sw_clear[gi])
                                || sw_set[gi] || hw_effective[gi];

        assign overflow_set[gi]  = hw_effective[gi] && value_reg[gi]
                                   && !(i_clear[gi] || sw_clear[gi]);
        assign overflow_next[gi] = overflow_set[gi] || (overflow_reg[gi] && !sw_clear[gi]);
    end

    assign irq_next = |(value_next & i_irq_enable);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            value_reg    <= INITIAL_VALUE;
            overflow_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            value_reg    <= value_next;
            overflow_reg <= overflow_next;
            irq_reg      <= irq_next;
        end
    end

    assign bit_field_if.read_data = value_reg;
    assign bit_field_if.value     = value_reg;
    assign o_value                = value_reg;
    assign o_overflow             = overflow_reg;
    assign o_irq                  = irq_reg;

endmodule
